// File: rtl/regfile_pkg.sv
// Shared constants and write-to-read bypass priority for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

  // Source of a read port's data: stored contents or one of the in-flight writes.
  typedef enum logic [1:0] {
    SRC_STORE = 2'd0,
    SRC_WR0   = 2'd1,
    SRC_WR1   = 2'd2
  } byp_src_e;

  // wr1 beats wr0 beats storage, matching the storage write order.
  function automatic byp_src_e byp_select(input logic bypass_on, input logic hit0,
                                          input logic hit1);
    if (!bypass_on) return SRC_STORE;
    if (hit1) return SRC_WR1;
    if (hit0) return SRC_WR0;
    return SRC_STORE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit tracker: alloc sets, completed writes clear, flush clears everything.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we0,
  input  logic [ADDR_W-1:0]    wa0,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    wa1,
  input  logic                 alloc_en,
  input  logic [ADDR_W-1:0]    alloc_addr,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] busy_vec
);

  logic [2**ADDR_W-1:0] busy_nxt;

  // Alloc is applied after the clears so a new producer wins over a retiring one.
  always_comb begin
    busy_nxt = busy_vec;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (we0) busy_nxt[wa0] = 1'b0;
      if (we1) busy_nxt[wa1] = 1'b0;
      if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRD-read register file with optional bypass and a pending-bit scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic              we0, we1;
  logic [DATA_W-1:0] mem [DEPTH];

  // Writes to a hardwired-zero register are dropped everywhere, including bypass.
  assign we0 = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign we1 = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[wr0_addr] <= wr0_data;
      if (we1) mem[wr1_addr] <= wr1_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .we0        (we0),
    .wa0        (wr0_addr),
    .we1        (we1),
    .wa1        (wr1_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1, alloc_hit;
    byp_src_e          src;
    logic [DATA_W-1:0] val;

    assign ra        = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit0      = we0 && (wr0_addr == ra);
    assign hit1      = we1 && (wr1_addr == ra);
    assign alloc_hit = alloc_en && (alloc_addr == ra);
    assign src       = byp_select(BYPASS != 0, hit0, hit1);

    always_comb begin
      val = '0;
      case (src)
        SRC_WR1: val = wr1_data;
        SRC_WR0: val = wr0_data;
        default: val = mem[ra];
      endcase
      // Bypass paths would leak write data while in reset, so gate the output.
      if (!rst_n || ((ZERO_REG != 0) && (ra == '0))) val = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = val;
    // A write landing this cycle resolves the hazard unless the same cycle re-allocates.
    assign rd_busy[k] = rst_n && busy_vec[ra] &&
                        !((BYPASS != 0) && (hit0 || hit1) && !alloc_hit);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed test of regfile_sb: bypass and non-bypass instances, scoreboard, async reset.
module tb_regfile_sb;

  localparam int K_RD0   = 0;
  localparam int K_RD1   = 1;
  localparam int K_RBUSY = 2;
  localparam int K_BVEC  = 3;
  localparam int K_NB0   = 4;
  localparam int K_NB1   = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr0_en, wr1_en, alloc_en, flush;
  logic [4:0]  wr0_addr, wr1_addr, alloc_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic [31:0] busy_vec, nb_busy_vec;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad = 0;
  event        sample_ev;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .busy_vec(busy_vec)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .busy_vec(nb_busy_vec)
  );

  // Monitor: drains every queued expectation when a sample point is announced.
  initial begin
    forever begin
      @(sample_ev);
      while (kind_q.size() > 0) begin
        int          k;
        logic [31:0] e, act;
        string       n;
        k = kind_q.pop_front();
        e = exp_q.pop_front();
        n = name_q.pop_front();
        case (k)
          K_RD0:   act = rd_data[31:0];
          K_RD1:   act = rd_data[63:32];
          K_RBUSY: act = {30'b0, rd_busy};
          K_BVEC:  act = busy_vec;
          K_NB0:   act = nb_rd_data[31:0];
          default: act = nb_rd_data[63:32];
        endcase
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  task automatic expect_v(input int k, input string n, input logic [31:0] v);
    kind_q.push_back(k);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic check();
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wr0_addr = '0; wr1_addr = '0; alloc_addr = '0;
    wr0_data = '0; wr1_data = '0; rd_addr = '0;

    // reset contents
    expect_v(K_BVEC, "in_reset_busy", 32'h0);
    check();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      expect_v(K_RD0, "reset_rd0", 32'h0);
      expect_v(K_RD1, "reset_rd1", 32'h0);
      check();
    end
    expect_v(K_BVEC, "reset_busy_vec", 32'h0);
    check();

    // same-cycle bypass vs next-cycle visibility
    step();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hDEADBEEF; set_rd(5'd3, 5'd0);
    expect_v(K_RD0, "byp_same_cycle", 32'hDEADBEEF);
    expect_v(K_NB0, "nobyp_same_cycle", 32'h0);
    check();
    step();
    idle();
    expect_v(K_RD0, "byp_next_cycle", 32'hDEADBEEF);
    expect_v(K_NB0, "nobyp_next_cycle", 32'hDEADBEEF);
    check();

    // wr1 wins a same-address collision
    step();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h22;
    set_rd(5'd5, 5'd5);
    expect_v(K_RD0, "collide_byp", 32'h22);
    check();
    step();
    idle();
    expect_v(K_RD1, "collide_stored", 32'h22);
    expect_v(K_NB0, "collide_nobyp", 32'h22);
    check();

    // register 0 stays zero and never busy
    step();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0; set_rd(5'd0, 5'd0);
    expect_v(K_RD0, "zero_byp", 32'h0);
    check();
    step();
    idle();
    expect_v(K_RD0, "zero_rd", 32'h0);
    expect_v(K_NB0, "zero_rd_nobyp", 32'h0);
    expect_v(K_BVEC, "zero_busy", 32'h0);
    check();

    // scoreboard: alloc, write+alloc, write alone, flush over alloc
    step();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    step();
    idle(); set_rd(5'd7, 5'd3);
    expect_v(K_RBUSY, "alloc_rd_busy", 32'h1);
    expect_v(K_BVEC, "alloc_busy_vec", 32'h80);
    check();
    step();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h5;
    alloc_en = 1'b1; alloc_addr = 5'd7;
    expect_v(K_RBUSY, "wr_alloc_rd_busy", 32'h1);
    expect_v(K_RD0, "wr_alloc_byp", 32'h5);
    check();
    step();
    idle();
    expect_v(K_BVEC, "wr_alloc_stays", 32'h80);
    expect_v(K_NB0, "wr_alloc_stored", 32'h5);
    check();
    step();
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h6;
    expect_v(K_RBUSY, "wr_forces_ready", 32'h0);
    expect_v(K_RD0, "wr1_byp", 32'h6);
    expect_v(K_NB0, "wr1_nobyp_old", 32'h5);
    check();
    step();
    idle();
    expect_v(K_BVEC, "wr_clears_busy", 32'h0);
    expect_v(K_RBUSY, "wr_clears_rd_busy", 32'h0);
    expect_v(K_NB0, "wr1_stored", 32'h6);
    check();
    step();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    step();
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'hAB; set_rd(5'd7, 5'd10);
    expect_v(K_BVEC, "pre_flush_busy", 32'h80);
    expect_v(K_RD1, "flush_wr_byp", 32'hAB);
    check();
    step();
    idle();
    expect_v(K_BVEC, "flush_busy_vec", 32'h0);
    expect_v(K_RBUSY, "flush_rd_busy", 32'h0);
    expect_v(K_NB1, "flush_wr_stored", 32'hAB);
    check();

    // asynchronous reset mid-cycle
    step();
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h101;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h102;
    step();
    wr0_addr = 5'd3; wr0_data = 32'h103;
    wr1_addr = 5'd4; wr1_data = 32'h104;
    step();
    idle(); set_rd(5'd1, 5'd4);
    alloc_en = 1'b1; alloc_addr = 5'd6;
    expect_v(K_RD0, "pre_rst_rd1", 32'h101);
    expect_v(K_RD1, "pre_rst_rd4", 32'h104);
    check();
    step();
    idle();
    expect_v(K_BVEC, "pre_rst_busy", 32'h40);
    check();
    rst_n = 1'b0;
    expect_v(K_RD0, "async_rst_rd0", 32'h0);
    expect_v(K_RD1, "async_rst_rd1", 32'h0);
    expect_v(K_NB0, "async_rst_nb0", 32'h0);
    expect_v(K_BVEC, "async_rst_busy", 32'h0);
    check();
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h77;
    alloc_en = 1'b1; alloc_addr = 5'd5;
    expect_v(K_RD0, "rst_gates_byp", 32'h0);
    expect_v(K_RBUSY, "rst_rd_busy", 32'h0);
    check();
    step();
    expect_v(K_NB0, "rst_ignores_wr", 32'h0);
    expect_v(K_BVEC, "rst_ignores_alloc", 32'h0);
    check();
    rst_n = 1'b1;
    expect_v(K_RD0, "post_rst_byp", 32'h77);
    expect_v(K_NB0, "post_rst_cleared", 32'h0);
    check();
    step();
    idle();
    expect_v(K_NB0, "first_edge_wr", 32'h77);
    expect_v(K_BVEC, "first_edge_alloc", 32'h20);
    check();

    step();
    if (kind_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", kind_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
